// File: rtl/fetch_unit_rv32i.sv
// rtl/fetch_unit_rv32i.sv - RV32I program counter and instruction-fetch sequencer
module fetch_unit_rv32i #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] PCin,
    input  logic        fetch_stall,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] PC,
    output logic [31:0] PCnew,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        misaligned,
    output logic [31:0] retired
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_EXEC  = 2'd2,
        S_TRAP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_instr;
    logic [31:0] w_instr_nxt;
    logic        r_misaligned;
    logic        w_misaligned_nxt;
    logic [31:0] r_retired;
    logic [31:0] w_retired_nxt;

    // State and architectural registers; reset abandons any in-flight fetch
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_instr      <= NOP;
            r_misaligned <= 1'b0;
            r_retired    <= 32'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_instr      <= w_instr_nxt;
            r_misaligned <= w_misaligned_nxt;
            r_retired    <= w_retired_nxt;
        end
    end

    // Next-state logic: fetch handshake, retire/commit, and misaligned trap
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_instr_nxt      = r_instr;
        w_misaligned_nxt = r_misaligned;
        w_retired_nxt    = r_retired;
        case (r_state)
            S_FETCH: begin
                // rvalid here belongs to an abandoned transaction and is dropped
                if (imem_gnt) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    w_instr_nxt = imem_rdata;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!fetch_stall) begin
                    w_retired_nxt = r_retired + 32'd1;
                    if (PCin[1:0] == 2'b00) begin
                        w_pc_nxt    = PCin;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_misaligned_nxt = 1'b1;
                        w_state_nxt      = S_TRAP;
                    end
                end
            end
            default: begin
                // TRAP is terminal until reset
                w_state_nxt = S_TRAP;
            end
        endcase
    end

    // Outputs depend only on registered state, never on gnt/rvalid
    assign imem_req    = (r_state == S_FETCH);
    assign imem_addr   = r_pc;
    assign PC          = r_pc;
    assign PCnew       = r_pc + 32'd4;
    assign instr       = r_instr;
    assign instr_valid = (r_state == S_EXEC);
    assign misaligned  = r_misaligned;
    assign retired     = r_retired;

endmodule

// File: tb/tb_fetch_unit_rv32i.sv
// tb/tb_fetch_unit_rv32i.sv - directed scoreboard bench for fetch_unit_rv32i
module tb_fetch_unit_rv32i;

    logic        clock;
    logic        reset;
    logic [31:0] PCin;
    logic        fetch_stall;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] PC;
    logic [31:0] PCnew;
    logic [31:0] instr;
    logic        instr_valid;
    logic        misaligned;
    logic [31:0] retired;

    fetch_unit_rv32i dut (
        .clock       (clock),
        .reset       (reset),
        .PCin        (PCin),
        .fetch_stall (fetch_stall),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .PC          (PC),
        .PCnew       (PCnew),
        .instr       (instr),
        .instr_valid (instr_valid),
        .misaligned  (misaligned),
        .retired     (retired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] instr_q[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_ret;
    logic [31:0] exp_instr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        exp_pc    = 32'h0000_0000;
        exp_ret   = 32'd0;
        exp_instr = 32'h0000_0013;
        instr_q.delete();
    endtask

    // One full instruction: FETCH (gnt after gnt_dly), WAIT (rvalid after rv_dly), EXEC (stall_n cycles)
    task automatic fetch_one(input int gnt_dly, input int rv_dly, input int stall_n,
                             input logic [31:0] pcin, input logic [31:0] rdata);
        logic [31:0] popped;
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, exp_pc);
        imem_gnt = 1'b0;
        for (int i = 0; i < gnt_dly; i++) begin
            step();
            chk("bp_req_stable", {31'd0, imem_req}, 32'd1);
            chk("bp_addr_stable", imem_addr, exp_pc);
        end
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        chk("wait_req_low", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < rv_dly; i++) begin
            step();
            chk("wait_hold_valid", {31'd0, instr_valid}, 32'd0);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = rdata;
        instr_q.push_back(rdata);
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        chk("exec_valid", {31'd0, instr_valid}, 32'd1);
        if (instr_q.size() > 0) popped = instr_q.pop_front();
        else popped = 32'hxxxx_xxxx;
        exp_instr = popped;
        chk("exec_instr", instr, exp_instr);
        chk("exec_pc", PC, exp_pc);
        chk("exec_pcnew", PCnew, exp_pc + 32'd4);
        chk("exec_retired", retired, exp_ret);
        fetch_stall = 1'b1;
        for (int i = 0; i < stall_n; i++) begin
            step();
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_pc", PC, exp_pc);
            chk("stall_instr", instr, exp_instr);
            chk("stall_retired", retired, exp_ret);
        end
        fetch_stall = 1'b0;
        PCin = pcin;
        step();
        exp_ret = exp_ret + 32'd1;
        chk("retire_count", retired, exp_ret);
        chk("retire_valid_low", {31'd0, instr_valid}, 32'd0);
        if (pcin[1:0] == 2'b00) begin
            exp_pc = pcin;
            chk("retire_pc", PC, exp_pc);
            chk("retire_req", {31'd0, imem_req}, 32'd1);
            chk("retire_mis_clear", {31'd0, misaligned}, 32'd0);
        end else begin
            chk("trap_mis", {31'd0, misaligned}, 32'd1);
            chk("trap_req_low", {31'd0, imem_req}, 32'd0);
            chk("trap_pc_held", PC, exp_pc);
        end
    endtask

    initial begin
        reset       = 1'b1;
        PCin        = 32'h0;
        fetch_stall = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        exp_pc      = 32'h0;
        exp_ret     = 32'h0;
        exp_instr   = 32'h0000_0013;
        step();
        step();
        reset = 1'b0;

        // Reset state
        chk("rst_pc", PC, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_req", {31'd0, imem_req}, 32'd1);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_mis", {31'd0, misaligned}, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_pcnew", PCnew, 32'h4);

        // Zero-wait sequential fetch: 0,4,8,C in 12 cycles
        fetch_one(0, 0, 0, 32'h4,  32'h0010_0093);
        fetch_one(0, 0, 0, 32'h8,  32'h0020_0113);
        fetch_one(0, 0, 0, 32'hC,  32'h0030_0193);
        fetch_one(0, 0, 0, 32'h10, 32'h0040_0213);
        chk("retired_after_12", retired, 32'd4);

        // Branch from 0x10 to 0x40, then PCnew=0x44 in the next EXEC
        fetch_one(0, 0, 0, 32'h40, 32'h0300_006F);
        fetch_one(0, 0, 0, 32'h44, 32'h0050_0293);

        // Backpressure: gnt held off 3 cycles, rvalid delayed 2 cycles
        fetch_one(3, 2, 0, 32'h48, 32'hCAFE_0337);

        // Stall 4 cycles in EXEC
        fetch_one(0, 0, 4, 32'h4C, 32'h1234_5037);

        // PC wrap: FFFFFFFC is legal, PCnew wraps to 0
        fetch_one(0, 0, 0, 32'hFFFF_FFFC, 32'h0000_0013);
        fetch_one(1, 1, 0, 32'h0, 32'h0070_0393);

        // Misaligned target traps
        fetch_one(0, 0, 0, 32'h22, 32'h0220_006F);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        imem_gnt    = 1'b1;
        step();
        step();
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b0;
        chk("trap_ignore_instr", instr, exp_instr);
        chk("trap_ignore_valid", {31'd0, instr_valid}, 32'd0);
        chk("trap_ignore_req", {31'd0, imem_req}, 32'd0);
        chk("trap_sticky", {31'd0, misaligned}, 32'd1);
        chk("trap_retired_held", retired, exp_ret);
        do_reset();
        chk("post_trap_mis", {31'd0, misaligned}, 32'd0);
        chk("post_trap_pc", PC, 32'h0);
        chk("post_trap_req", {31'd0, imem_req}, 32'd1);
        chk("post_trap_retired", retired, 32'd0);

        // Reset mid-WAIT, then a stale rvalid in FETCH must be dropped
        fetch_one(0, 0, 0, 32'h8, 32'h0080_0413);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        chk("midwait_req_low", {31'd0, imem_req}, 32'd0);
        do_reset();
        chk("midwait_rst_pc", PC, 32'h0);
        chk("midwait_rst_req", {31'd0, imem_req}, 32'd1);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        chk("stale_instr", instr, 32'h0000_0013);
        chk("stale_valid", {31'd0, instr_valid}, 32'd0);
        chk("stale_req", {31'd0, imem_req}, 32'd1);
        fetch_one(0, 0, 0, 32'h4, 32'h0090_0493);
        chk("genuine_instr", instr, 32'h0090_0493);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit_rv32i.md
Name: fetch_unit_rv32i

Overview:
Program-counter register and instruction-fetch sequencer for the multi-cycle RV32I core. It holds the architectural PC, fetches the word at PC over a req/gnt/rvalid instruction-memory interface, and presents the instruction to decode. It also drives PCnew = PC+4 to the brancher and commits the brancher's PCin as the next PC once the instruction retires. It additionally counts retired instructions and traps on misaligned targets.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
clock  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
PCin  input  32  next PC from the brancher; sampled only on retire.
fetch_stall  input  1  core not ready to retire the current instruction; holds EXEC.
imem_gnt  input  1  memory accepts the request this cycle.
imem_rvalid  input  1  imem_rdata is valid this cycle.
imem_rdata  input  32  fetched instruction word.
imem_req  output  1  fetch request.
imem_addr  output  32  fetch address, always equal to PC.
PC  output  32  address of the current instruction.
PCnew  output  32  PC+4, combinational, modulo 2^32.
instr  output  32  latched instruction word.
instr_valid  output  1  instr is valid and executing.
misaligned  output  1  sticky trap flag.
retired  output  32  retired-instruction count.

Behaviour:
- Reset (async, immediate): state=FETCH, PC=RESET_PC, instr=32'h0000_0013 (NOP), instr_valid=0, misaligned=0, retired=0, imem_req=1 on the first cycle after deassertion. Reset mid-fetch abandons the transaction. Any later imem_rvalid is ignored unless the state is WAIT.
- States: FETCH, WAIT, EXEC, TRAP.
- FETCH: imem_req=1, imem_addr=PC. If imem_gnt=1, go to WAIT; otherwise stay with the request held stable.
- WAIT: imem_req=0. If imem_rvalid=1, instr<=imem_rdata and go to EXEC; otherwise stay. rvalid is never expected in the same cycle as gnt; rvalid seen in FETCH is ignored.
- EXEC: instr_valid=1. If fetch_stall=1, hold the state; PC and instr stay unchanged.
- EXEC retire (fetch_stall=0):
  - retired<=retired+1 (wraps 2^32-1 -> 0).
  - If PCin[1:0]==0: PC<=PCin, go to FETCH.
  - Otherwise: PC unchanged, misaligned<=1, go to TRAP.
- TRAP: imem_req=0, instr_valid=0. Only reset exits TRAP.
- instr_valid=1 exactly in EXEC.
- Minimum latency is 3 cycles per instruction (gnt on the first FETCH cycle, rvalid on the next cycle, no stall).
- PC wrap: PCin=32'hFFFF_FFFC is legal. PCnew then equals 32'h0000_0000.
- imem_addr/imem_req are registered-state-derived only; no combinational path from imem_gnt or imem_rvalid to outputs.

Test Plan:
- Reset with RESET_PC=0, zero-wait memory (gnt immediate, rvalid next cycle), PCin=PCnew each retire -> imem_addr 0,4,8,C on successive FETCH; instr_valid pulses every 3rd cycle; retired=4 after 12 cycles.
- Branch: in EXEC at PC=0x10 drive PCin=0x40 -> next imem_addr=0x40; PCnew=0x44 in the following EXEC.
- Backpressure: hold imem_gnt=0 for 3 cycles, then delay rvalid by 2 cycles -> imem_req/imem_addr stable throughout; instr matches rdata; retired increments once.
- Stall: fetch_stall=1 for 4 cycles in EXEC -> instr_valid held high; PC, instr and retired unchanged; advance on the cycle stall drops.
- Misaligned: in EXEC drive PCin=0x22 -> misaligned=1, state TRAP, imem_req=0. Ignore further rvalid. Assert reset -> misaligned=0, PC=RESET_PC.
- Reset mid-WAIT, then stale rvalid with rdata=0xDEADBEEF in FETCH -> ignored; instr=0x00000013 until the genuine fetch completes.
